piano_voice: RTL and testbench

Parametrised single-voice tone engine for the electric piano. It takes the debounced key-state vector from the matrix scanner, picks one key by fixed priority, and produces a square-wave beeper output from a per-key half-period table. It adds an octave shift, a timed sustain tail after key release, and glitch-free note retargeting. It sits between the keyboard scanner and the beeper pin, replacing the fixed 16-key beeper stage.

---
 rtl/piano_voice_if.sv | 26 ++
 rtl/piano_voice.sv | 148 ++++++++++++++
 tb/tb_piano_voice.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/piano_voice_if.sv
// piano_voice_if: key/octave/enable controls into the tone engine and
// the beeper/status outputs back out, bundled as one port.
interface piano_voice_if #(
  parameter int KEYS = 16
) ();
  localparam int IDX_W = $clog2(KEYS);

  logic [KEYS-1:0]  key_state;
  logic [1:0]       octave;
  logic             enable;
  logic             beeper;
  logic             active;
  logic [IDX_W-1:0] note_idx;

  // Controller / keyboard side
  modport master (
    output key_state, octave, enable,
    input  beeper, active, note_idx
  );

  // Tone engine side
  modport slave (
    input  key_state, octave, enable,
    output beeper, active, note_idx
  );
endinterface

// File: rtl/piano_voice.sv
// piano_voice: single-voice square-wave tone engine. Picks the lowest
// pressed key, divides clk by that key's half-period (optionally shifted
// up by octaves), keeps sounding for a timed sustain tail after release,
// and retargets between notes without an extra beeper toggle.
module piano_voice #(
  parameter int KEYS  = 16,
  parameter int DIV_W = 20,
  parameter logic [KEYS*DIV_W-1:0] HALF_PERIODS = {
    20'd5733,  20'd6074,  20'd6818,  20'd7653,
    20'd8590,  20'd9101,  20'd10215, 20'd11467,
    20'd11467, 20'd12148, 20'd13636, 20'd15306,
    20'd17181, 20'd18202, 20'd20431, 20'd22934
  },
  parameter int SUS_W          = 24,
  parameter int SUSTAIN_CYCLES = 1200000
) (
  input logic         clk,
  input logic         rst,
  piano_voice_if.slave bus
);
  localparam int IDX_W = $clog2(KEYS);

  typedef enum logic [1:0] {IDLE, PLAY, SUSTAIN} state_t;

  state_t           state;
  logic [KEYS-1:0]  key_q;
  logic [DIV_W-1:0] half_r;
  logic [DIV_W-1:0] tone_cnt;
  logic [SUS_W-1:0] sus_cnt;
  logic             beeper_reg;
  logic             active_reg;
  logic [IDX_W-1:0] note_reg;

  logic [DIV_W-1:0] half_tab [KEYS];
  logic [IDX_W-1:0] sel;
  logic             any_key;
  logic [DIV_W-1:0] shifted;
  logic [DIV_W-1:0] eff;
  logic [DIV_W-1:0] tone_cnt_next;
  logic             beeper_next;

  // Unpack the flat half-period parameter into a per-key table
  genvar gi;
  generate
    for (gi = 0; gi < KEYS; gi++) begin : g_tab
      assign half_tab[gi] = HALF_PERIODS[gi*DIV_W +: DIV_W];
    end
  endgenerate

  // Fixed priority: lowest-index pressed key wins (scan from the top down)
  always_comb begin
    sel = '0;
    for (int k = KEYS - 1; k >= 0; k--) begin
      if (key_q[k]) sel = IDX_W'(k);
    end
  end

  assign any_key = |key_q;
  assign shifted = half_tab[sel] >> bus.octave;
  // A half-period of 0 would never wrap, so clamp deep octave shifts to 1
  assign eff     = (shifted == '0) ? DIV_W'(1) : shifted;

  // Free-running tone divider step used while a note is sounding
  always_comb begin
    tone_cnt_next = tone_cnt + DIV_W'(1);
    beeper_next   = beeper_reg;
    if (tone_cnt == half_r - DIV_W'(1)) begin
      tone_cnt_next = '0;
      beeper_next   = ~beeper_reg;
    end
  end

  // Key register plus the IDLE/PLAY/SUSTAIN voice FSM with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_q      <= '0;
      state      <= IDLE;
      half_r     <= DIV_W'(1);
      tone_cnt   <= '0;
      sus_cnt    <= '0;
      beeper_reg <= 1'b0;
      active_reg <= 1'b0;
      note_reg   <= '0;
    end else begin
      key_q <= bus.key_state;
      if (!bus.enable) begin
        state      <= IDLE;
        beeper_reg <= 1'b0;
        active_reg <= 1'b0;
        tone_cnt   <= '0;
        sus_cnt    <= '0;
      end else begin
        case (state)
          IDLE: begin
            beeper_reg <= 1'b0;
            active_reg <= 1'b0;
            tone_cnt   <= '0;
            if (any_key) begin
              note_reg   <= sel;
              half_r     <= eff;
              active_reg <= 1'b1;
              state      <= PLAY;
            end
          end
          PLAY: begin
            if (any_key && sel != note_reg) begin
              // Retarget: restart the divider but keep the current level
              note_reg <= sel;
              half_r   <= eff;
              tone_cnt <= '0;
            end else begin
              tone_cnt   <= tone_cnt_next;
              beeper_reg <= beeper_next;
              if (!any_key) begin
                state   <= SUSTAIN;
                sus_cnt <= '0;
              end
            end
          end
          SUSTAIN: begin
            if (any_key) begin
              // Always reload so a new octave setting takes effect
              note_reg <= sel;
              half_r   <= eff;
              tone_cnt <= '0;
              state    <= PLAY;
            end else if (sus_cnt == SUS_W'(SUSTAIN_CYCLES - 1)) begin
              state      <= IDLE;
              beeper_reg <= 1'b0;
              active_reg <= 1'b0;
              tone_cnt   <= '0;
              sus_cnt    <= '0;
            end else begin
              sus_cnt    <= sus_cnt + SUS_W'(1);
              tone_cnt   <= tone_cnt_next;
              beeper_reg <= beeper_next;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.beeper   = beeper_reg;
  assign bus.active   = active_reg;
  assign bus.note_idx = note_reg;
endmodule

// File: tb/tb_piano_voice.sv
// tb_piano_voice: directed scenarios for the tone engine. Each scenario
// queues the output changes it expects (cycle, beeper, active, note_idx);
// an independent monitor pops one entry whenever the outputs change.
module tb_piano_voice;
  logic clk;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;

  typedef struct {
    int         c;
    logic       b;
    logic       a;
    logic [1:0] n;
  } ev_t;

  ev_t exp_q[$];

  piano_voice_if #(.KEYS(4)) bus ();

  piano_voice #(
    .KEYS(4),
    .DIV_W(8),
    .HALF_PERIODS({8'd10, 8'd8, 8'd6, 8'd4}),
    .SUS_W(8),
    .SUSTAIN_CYCLES(20)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, int act, int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
    end
  endfunction

  function automatic void expect_ev(int c, logic b, logic a, logic [1:0] n);
    ev_t e;
    e.c = c;
    e.b = b;
    e.a = a;
    e.n = n;
    exp_q.push_back(e);
  endfunction

  task automatic wait_until(int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: on every output change pop and compare the next expectation
  initial begin
    logic [3:0] last;
    logic [3:0] cur;
    ev_t e;
    last = 4'b0000;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        cur = {bus.beeper, bus.active, bus.note_idx};
        if (cur !== last) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_event: cycle %0d beeper=%0b active=%0b note=%0d, none expected",
                     cyc, cur[3], cur[2], cur[1:0]);
          end else begin
            e = exp_q.pop_front();
            $display("event cycle=%0d beeper=%0b active=%0b note=%0d (expected cycle=%0d beeper=%0b active=%0b note=%0d)",
                     cyc, cur[3], cur[2], cur[1:0], e.c, e.b, e.a, e.n);
            chk("event_cycle", cyc, e.c);
            chk("event_beeper", int'(cur[3]), int'(e.b));
            chk("event_active", int'(cur[2]), int'(e.a));
            chk("event_note", int'(cur[1:0]), int'(e.n));
          end
          last = cur;
        end
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    rst           = 1'b1;
    bus.key_state = 4'b0000;
    bus.octave    = 2'd0;
    bus.enable    = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_beeper", int'(bus.beeper), 0);
    chk("reset_active", int'(bus.active), 0);
    chk("reset_note", int'(bus.note_idx), 0);
    rst    = 1'b0;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);

    // A: start on key 0 (half 4, period 8), then mute while beeper is high
    @(negedge clk);
    t = cyc;
    expect_ev(t + 2,  1'b0, 1'b1, 2'd0);
    expect_ev(t + 6,  1'b1, 1'b1, 2'd0);
    expect_ev(t + 10, 1'b0, 1'b1, 2'd0);
    expect_ev(t + 14, 1'b1, 1'b1, 2'd0);
    expect_ev(t + 16, 1'b0, 1'b0, 2'd0);
    bus.key_state = 4'b0001;
    wait_until(t + 15);
    bus.key_state = 4'b0000;
    bus.enable    = 1'b0;
    wait_until(t + 17);
    bus.enable    = 1'b1;
    wait_until(t + 20);

    // B: key 2 (half 8), add key 1 (half 6), release key 1 back to key 2
    @(negedge clk);
    t = cyc;
    expect_ev(t + 2,  1'b0, 1'b1, 2'd2);
    expect_ev(t + 10, 1'b1, 1'b1, 2'd2);
    expect_ev(t + 18, 1'b0, 1'b1, 2'd2);
    expect_ev(t + 22, 1'b0, 1'b1, 2'd1);
    expect_ev(t + 28, 1'b1, 1'b1, 2'd1);
    expect_ev(t + 34, 1'b0, 1'b1, 2'd1);
    expect_ev(t + 37, 1'b0, 1'b1, 2'd2);
    expect_ev(t + 45, 1'b1, 1'b1, 2'd2);
    expect_ev(t + 53, 1'b0, 1'b1, 2'd2);
    expect_ev(t + 55, 1'b0, 1'b0, 2'd2);
    bus.key_state = 4'b0100;
    wait_until(t + 20);
    bus.key_state = 4'b0110;
    wait_until(t + 35);
    bus.key_state = 4'b0100;
    wait_until(t + 54);
    bus.key_state = 4'b0000;
    bus.enable    = 1'b0;
    wait_until(t + 56);
    bus.enable    = 1'b1;
    wait_until(t + 58);

    // C: key 3 at octave 2 (half 2), octave change mid-note, key 0 at octave 3 (clamped to 1)
    @(negedge clk);
    t = cyc;
    expect_ev(t + 2,  1'b0, 1'b1, 2'd3);
    expect_ev(t + 4,  1'b1, 1'b1, 2'd3);
    expect_ev(t + 6,  1'b0, 1'b1, 2'd3);
    expect_ev(t + 8,  1'b1, 1'b1, 2'd3);
    expect_ev(t + 10, 1'b0, 1'b1, 2'd3);
    expect_ev(t + 12, 1'b1, 1'b1, 2'd3);
    expect_ev(t + 14, 1'b0, 1'b1, 2'd3);
    expect_ev(t + 16, 1'b1, 1'b1, 2'd3);
    expect_ev(t + 18, 1'b0, 1'b1, 2'd3);
    expect_ev(t + 20, 1'b0, 1'b1, 2'd0);
    expect_ev(t + 21, 1'b1, 1'b1, 2'd0);
    expect_ev(t + 22, 1'b0, 1'b1, 2'd0);
    expect_ev(t + 23, 1'b1, 1'b1, 2'd0);
    expect_ev(t + 24, 1'b0, 1'b1, 2'd0);
    expect_ev(t + 25, 1'b0, 1'b0, 2'd0);
    bus.octave    = 2'd2;
    bus.key_state = 4'b1000;
    wait_until(t + 10);
    bus.octave    = 2'd0;
    wait_until(t + 18);
    bus.octave    = 2'd3;
    bus.key_state = 4'b0001;
    wait_until(t + 24);
    bus.key_state = 4'b0000;
    bus.enable    = 1'b0;
    wait_until(t + 26);
    bus.enable    = 1'b1;
    bus.octave    = 2'd0;
    wait_until(t + 28);

    // D: key 1 (half 6), release; tail of 20 cycles then IDLE
    @(negedge clk);
    t = cyc;
    expect_ev(t + 2,  1'b0, 1'b1, 2'd1);
    expect_ev(t + 8,  1'b1, 1'b1, 2'd1);
    expect_ev(t + 14, 1'b0, 1'b1, 2'd1);
    expect_ev(t + 20, 1'b1, 1'b1, 2'd1);
    expect_ev(t + 26, 1'b0, 1'b1, 2'd1);
    expect_ev(t + 32, 1'b1, 1'b1, 2'd1);
    expect_ev(t + 36, 1'b0, 1'b0, 2'd1);
    bus.key_state = 4'b0010;
    wait_until(t + 14);
    bus.key_state = 4'b0000;
    wait_until(t + 40);

    // E: same release, re-press key 1 at octave 1 so it is seen at sus_cnt = 19
    @(negedge clk);
    t = cyc;
    expect_ev(t + 2,  1'b0, 1'b1, 2'd1);
    expect_ev(t + 8,  1'b1, 1'b1, 2'd1);
    expect_ev(t + 14, 1'b0, 1'b1, 2'd1);
    expect_ev(t + 20, 1'b1, 1'b1, 2'd1);
    expect_ev(t + 26, 1'b0, 1'b1, 2'd1);
    expect_ev(t + 32, 1'b1, 1'b1, 2'd1);
    expect_ev(t + 39, 1'b0, 1'b1, 2'd1);
    expect_ev(t + 42, 1'b1, 1'b1, 2'd1);
    expect_ev(t + 45, 1'b0, 1'b1, 2'd1);
    expect_ev(t + 46, 1'b0, 1'b0, 2'd1);
    bus.key_state = 4'b0010;
    wait_until(t + 14);
    bus.key_state = 4'b0000;
    wait_until(t + 34);
    bus.key_state = 4'b0010;
    bus.octave    = 2'd1;
    wait_until(t + 45);
    bus.key_state = 4'b0000;
    bus.enable    = 1'b0;
    wait_until(t + 47);
    bus.enable    = 1'b1;
    bus.octave    = 2'd0;
    wait_until(t + 50);

    // F: key 0 sounding, asynchronous reset between edges while beeper is high
    @(negedge clk);
    t = cyc;
    expect_ev(t + 2, 1'b0, 1'b1, 2'd0);
    expect_ev(t + 6, 1'b1, 1'b1, 2'd0);
    expect_ev(t + 8, 1'b0, 1'b0, 2'd0);
    bus.key_state = 4'b0001;
    wait_until(t + 7);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset_beeper", int'(bus.beeper), 0);
    chk("async_reset_active", int'(bus.active), 0);
    @(negedge clk);
    bus.key_state = 4'b0000;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    chk("pending_events", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
